pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit_pkg.sv | 15 +
 rtl/fetch_timeout.sv | 37 +++
 rtl/pc_fetch_unit.sv | 121 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants for the PC fetch unit: FSM state encoding and control levels.
package pc_fetch_unit_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_ERR   = 2'd2;

    localparam logic CHIP_ENA  = 1'b1;
    localparam logic CHIP_DISA = 1'b0;
    localparam logic NO_STOP   = 1'b0;
    localparam logic RST_ENA   = 1'b0;

endpackage

// File: rtl/fetch_timeout.sv
// Counts consecutive unacknowledged fetch requests; flags the cycle that reaches TIMEOUT.
module fetch_timeout #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    input  logic clear,
    output logic expired_c
);
    import pc_fetch_unit_pkg::*;

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_tmo;
            assign unused_tmo = ^{clk, rst, count_en, clear};
            assign expired_c  = 1'b0;
        end else begin : g_on
            localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
            logic [CNT_W-1:0] cnt;

            always_ff @(posedge clk) begin
                if (rst == RST_ENA) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= '0;
                end else if (count_en) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end

            // Expiry fires on the increment that brings the count to TIMEOUT.
            assign expired_c = count_en & ~clear & (cnt == CNT_W'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch PC generator with deferred branch capture, flush and fetch timeout.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h00000000),
    parameter int unsigned       INC      = 4,
    parameter int unsigned       STALL_W  = 6,
    parameter int unsigned       TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_address_i,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  new_pc_i,
    input  logic               imem_ack_i,
    output logic [ADDR_W-1:0]  pc,
    output logic               ce,
    output logic               imem_req_o,
    output logic               pending_o,
    output logic               fetch_err_o
);

    logic [STATE_W-1:0] state, state_nx;
    logic [ADDR_W-1:0]  pc_nx, pend_tgt, pend_tgt_nx;
    logic               ce_nx, pend_nx, err_nx;
    logic               stop, advance, flush_act, expired_c;
    logic               unused_stall;

    assign unused_stall = ^(stall >> 1);
    assign stop         = (stall[0] != NO_STOP);
    assign imem_req_o   = ce & (state == ST_RUN) & ~stop;
    assign advance      = imem_req_o & imem_ack_i;
    assign flush_act    = flush_i & (state != ST_RESET);

    fetch_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .count_en  (imem_req_o & ~imem_ack_i),
        .clear     (advance | stop | flush_act),
        .expired_c (expired_c)
    );

    always_ff @(posedge clk) begin
        if (rst == RST_ENA) begin
            state       <= ST_RESET;
            pc          <= RESET_PC;
            ce          <= CHIP_DISA;
            pending_o   <= 1'b0;
            pend_tgt    <= '0;
            fetch_err_o <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            ce          <= ce_nx;
            pending_o   <= pend_nx;
            pend_tgt    <= pend_tgt_nx;
            fetch_err_o <= err_nx;
        end
    end

    // Next-state: flush overrides everything; otherwise advance or capture the branch.
    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        ce_nx       = ce;
        pend_nx     = pending_o;
        pend_tgt_nx = pend_tgt;
        err_nx      = fetch_err_o;

        case (state)
            ST_RESET: begin
                state_nx = ST_RUN;
                ce_nx    = CHIP_ENA;
            end
            ST_RUN: begin
                if (advance) begin
                    if (branch_flag_i) begin
                        pc_nx = branch_target_address_i;
                    end else if (pending_o) begin
                        pc_nx = pend_tgt;
                    end else begin
                        pc_nx = pc + ADDR_W'(INC);
                    end
                    pend_nx     = 1'b0;
                    pend_tgt_nx = '0;
                end else if (branch_flag_i) begin
                    pend_nx     = 1'b1;
                    pend_tgt_nx = branch_target_address_i;
                end
                if (expired_c) begin
                    state_nx = ST_ERR;
                    err_nx   = 1'b1;
                end
            end
            ST_ERR: begin
                if (branch_flag_i) begin
                    pend_nx     = 1'b1;
                    pend_tgt_nx = branch_target_address_i;
                end
            end
            default: begin
                state_nx = ST_RESET;
                ce_nx    = CHIP_DISA;
            end
        endcase

        if (flush_act) begin
            state_nx    = ST_RUN;
            pc_nx       = new_pc_i;
            pend_nx     = 1'b0;
            pend_tgt_nx = '0;
            err_nx      = 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed scenarios plus randomized traffic, checked every cycle against a behavioural model.
module tb_pc_fetch_unit;

    localparam int unsigned AW  = 32;
    localparam int unsigned SW  = 6;
    localparam int unsigned TMO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [SW-1:0] stall;
    logic          branch_flag_i;
    logic [AW-1:0] branch_target_address_i;
    logic          flush_i;
    logic [AW-1:0] new_pc_i;
    logic          imem_ack_i;
    logic [AW-1:0] pc;
    logic          ce, imem_req_o, pending_o, fetch_err_o;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit #(
        .ADDR_W   (AW),
        .RESET_PC (32'h00000000),
        .INC      (4),
        .STALL_W  (SW),
        .TIMEOUT  (TMO)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .flush_i                 (flush_i),
        .new_pc_i                (new_pc_i),
        .imem_ack_i              (imem_ack_i),
        .pc                      (pc),
        .ce                      (ce),
        .imem_req_o              (imem_req_o),
        .pending_o               (pending_o),
        .fetch_err_o             (fetch_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: started = out of reset, err = timed out.
    bit          m_valid = 1'b0;
    bit          m_started, m_err, m_pend;
    logic [31:0] m_pc, m_tgt;
    int          m_cnt;

    always @(posedge clk) begin
        bit req, adv;
        if (!rst) begin
            m_started = 0; m_err = 0; m_pend = 0;
            m_pc = 32'h0; m_tgt = 32'h0; m_cnt = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (!m_started) begin
                m_started = 1;
            end else begin
                req = !m_err && !stall[0];
                adv = req && imem_ack_i;
                if (flush_i) begin
                    m_pc = new_pc_i; m_pend = 0; m_err = 0; m_cnt = 0;
                end else begin
                    if (adv) begin
                        m_pc   = branch_flag_i ? branch_target_address_i :
                                 m_pend ? m_tgt : m_pc + 32'd4;
                        m_pend = 0;
                    end else if (branch_flag_i) begin
                        m_pend = 1; m_tgt = branch_target_address_i;
                    end
                    if (adv || stall[0]) begin
                        m_cnt = 0;
                    end else if (req) begin
                        m_cnt++;
                        if (m_cnt == TMO) m_err = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_pc",      pc,          m_pc);
            check("model_ce",      32'(ce),          32'(m_started));
            check("model_pending", 32'(pending_o),   32'(m_pend));
            check("model_err",     32'(fetch_err_o), 32'(m_err));
            check("model_req",     32'(imem_req_o),
                  32'(m_started && !m_err && !stall[0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; stall = '0; branch_flag_i = 1'b0; branch_target_address_i = '0;
        flush_i = 1'b0; new_pc_i = '0; imem_ack_i = 1'b0;

        // Reset, then free-running fetch with ack held high
        tick(); tick();
        check("rst_pc", pc, 32'h0);
        check("rst_ce", 32'(ce), 32'h0);
        check("rst_req", 32'(imem_req_o), 32'h0);
        rst = 1'b1; imem_ack_i = 1'b1;
        tick();
        check("rel_ce", 32'(ce), 32'h1);
        check("rel_pc0", pc, 32'h0);
        tick();
        check("seq_pc4", pc, 32'h4);
        tick();
        check("seq_pc8", pc, 32'h8);

        // Deferred branch under stall
        stall = 6'b000001; flush_i = 1'b1; new_pc_i = 32'h100;
        tick();
        flush_i = 1'b0; check("set_pc100", pc, 32'h100);
        branch_flag_i = 1'b1; branch_target_address_i = 32'h400;
        tick();
        branch_flag_i = 1'b0;
        tick(); tick();
        check("stall_pend", 32'(pending_o), 32'h1);
        check("stall_pc", pc, 32'h100);
        stall = '0;
        tick();
        check("pend_pc", pc, 32'h400);
        check("pend_clr", 32'(pending_o), 32'h0);
        stall = 6'b000001;

        // Flush beats branch in the same cycle
        flush_i = 1'b1; new_pc_i = 32'h80; branch_flag_i = 1'b1; branch_target_address_i = 32'h400;
        tick();
        flush_i = 1'b0; branch_flag_i = 1'b0;
        check("flush_pc", pc, 32'h80);
        check("flush_pend", 32'(pending_o), 32'h0);

        // Timeout after TMO unacked requests, branch captured in ERR, flush recovers
        stall = '0; imem_ack_i = 1'b0;
        tick(); tick(); tick();
        check("tmo_not_yet", 32'(fetch_err_o), 32'h0);
        tick();
        check("tmo_err", 32'(fetch_err_o), 32'h1);
        check("tmo_req", 32'(imem_req_o), 32'h0);
        branch_flag_i = 1'b1; branch_target_address_i = 32'h500;
        tick();
        branch_flag_i = 1'b0;
        check("err_pend", 32'(pending_o), 32'h1);
        check("err_pc_hold", pc, 32'h80);
        flush_i = 1'b1; new_pc_i = 32'h200;
        tick();
        flush_i = 1'b0;
        check("recover_pc", pc, 32'h200);
        check("recover_err", 32'(fetch_err_o), 32'h0);
        check("recover_req", 32'(imem_req_o), 32'h1);

        // Wraparound
        stall = 6'b000001; flush_i = 1'b1; new_pc_i = 32'hFFFFFFFC;
        tick();
        flush_i = 1'b0; stall = '0; imem_ack_i = 1'b1;
        tick();
        check("wrap_pc", pc, 32'h0);

        // Reset while pending and in ERR overrides flush and branch
        stall = 6'b000001; flush_i = 1'b1; new_pc_i = 32'h300;
        tick();
        flush_i = 1'b0; stall = '0; imem_ack_i = 1'b0;
        branch_flag_i = 1'b1; branch_target_address_i = 32'h600;
        tick(); tick(); tick(); tick();
        check("pre_rst_err", 32'(fetch_err_o), 32'h1);
        check("pre_rst_pend", 32'(pending_o), 32'h1);
        rst = 1'b0; flush_i = 1'b1;
        tick();
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_ce", 32'(ce), 32'h0);
        check("mid_rst_pend", 32'(pending_o), 32'h0);
        check("mid_rst_err", 32'(fetch_err_o), 32'h0);
        check("mid_rst_req", 32'(imem_req_o), 32'h0);
        rst = 1'b1; flush_i = 1'b0; branch_flag_i = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 199) != 0);
            flush_i       = ($urandom_range(0, 15) == 0);
            branch_flag_i = ($urandom_range(0, 3) == 0);
            branch_target_address_i = $urandom() & 32'hFFFFFFFC;
            new_pc_i      = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | ($urandom() & 32'hC))
                                                         : ($urandom() & 32'hFFFFFFFC);
            stall         = SW'($urandom());
            stall[0]      = ($urandom_range(0, 3) == 0);
            imem_ack_i    = ($urandom_range(0, 2) != 0);
            tick();
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
